// File: rtl/cam_cfg_seq_if.sv
// -----------------------------------------------------------------------------
// cam_cfg_seq_if
//
// Purpose:
//   Bundles the signals between the camera configuration sequencer and its two
//   peers: the register lookup table and the SCCB/I2C write engine.
//
// Signals:
//   lut_index [IDX_W-1:0]  sequencer -> table   : table address
//   lut_data  [23:0]       table -> sequencer   : {reg_addr[15:0], reg_val[7:0]}
//   i2c_data  [31:0]       sequencer -> engine  : {dev_addr, reg_addr, reg_val}
//   start                  sequencer -> engine  : low clears, high runs
//   tr_end                 engine -> sequencer  : transfer finished
//   ack                    engine -> sequencer  : 0 = every byte ACKed
//
// Modports:
//   master : the sequencer side
//   slave  : the table/engine side
// -----------------------------------------------------------------------------
interface cam_cfg_seq_if #(
  parameter int IDX_W = 8
);
  logic [IDX_W-1:0] lut_index;
  logic [23:0]      lut_data;
  logic [31:0]      i2c_data;
  logic             start;
  logic             tr_end;
  logic             ack;

  modport master (
    output lut_index,
    output i2c_data,
    output start,
    input  lut_data,
    input  tr_end,
    input  ack
  );

  modport slave (
    input  lut_index,
    input  i2c_data,
    input  start,
    output lut_data,
    output tr_end,
    output ack
  );
endinterface

// File: rtl/cam_cfg_seq.sv
// -----------------------------------------------------------------------------
// cam_cfg_seq
//
// Purpose:
//   Camera register-configuration sequencer. After a power-up delay it walks
//   the register lookup table and issues one 32-bit SCCB write per entry
//   through the I2C write engine, checking each transfer for NACK or timeout.
//
// Optional feature:
//   CAM_CFG_RETRY_EN - when defined, a failed entry is rerun up to MAX_RETRY
//   extra times before giving up. When undefined, the first failure is final
//   and neither MAX_RETRY nor the retry counter exists.
//
// Ports:
//   clock_i2c    in   I2C bit clock, rising edge only
//   camera_rstn  in   asynchronous active-low reset
//   cfg_restart  in   one-cycle pulse, reruns the table from DONE or ERR
//   bus          --   cam_cfg_seq_if.master (table + write engine signals)
//   cfg_busy     out  configuration in progress
//   cfg_done     out  whole table written successfully (level)
//   cfg_err      out  an entry failed for good (level)
// -----------------------------------------------------------------------------
module cam_cfg_seq #(
  parameter logic [7:0] DEV_ADDR  = 8'h78,
  parameter int         LUT_SIZE  = 250,
  parameter int         IDX_W     = 8,
  parameter int         INIT_DLY  = 400,
  parameter int         TIMEOUT   = 63
`ifdef CAM_CFG_RETRY_EN
  ,
  parameter int         MAX_RETRY = 3
`endif
) (
  input  logic          clock_i2c,
  input  logic          camera_rstn,
  input  logic          cfg_restart,
  cam_cfg_seq_if.master bus,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_err
);

  // Counters only ever hold 0..N-1 before the state moves on.
  localparam int DLY_W = (INIT_DLY > 1) ? $clog2(INIT_DLY) : 1;
  localparam int TO_W  = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
`ifdef CAM_CFG_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`endif

  typedef enum logic [2:0] {
    S_PWR,
    S_LOAD,
    S_ARM,
    S_BUSY,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_lut_index;
  logic [31:0]        r_i2c_data;
  logic [DLY_W-1:0]   r_dly_cnt;
  logic               r_load_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_to_flag;
`ifdef CAM_CFG_RETRY_EN
  logic [RTY_W-1:0]   r_retry_cnt;
  logic               w_retry_inc;
  logic               w_retry_clr;
`endif

  logic w_start;
  logic w_busy;
  logic w_done;
  logic w_err;
  logic w_cap;
  logic w_idx_inc;
  logic w_idx_clr;
  logic w_to_fail;
  logic w_ok;
  logic w_last;
  logic w_to_hit;
  logic w_dly_hit;

  // A timeout failure is latched on the way into CHECK so that CHECK can
  // combine it with the ack it samples there.
  assign w_ok      = ~bus.ack & ~r_to_flag;
  assign w_last    = (r_lut_index == IDX_W'(LUT_SIZE - 1));
  assign w_to_hit  = (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_dly_hit = (r_dly_cnt == DLY_W'(INIT_DLY - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i2c or negedge camera_rstn) begin
    if (!camera_rstn) begin
      r_state <= S_PWR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b1;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_cap        = 1'b0;
    w_idx_inc    = 1'b0;
    w_idx_clr    = 1'b0;
    w_to_fail    = 1'b0;
`ifdef CAM_CFG_RETRY_EN
    w_retry_inc  = 1'b0;
    w_retry_clr  = 1'b0;
`endif
    case (r_state)
      S_PWR: begin
        if (w_dly_hit) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        // Second cycle captures the table word, giving a registered ROM
        // one full cycle to answer the new index.
        w_start = 1'b0;
        if (r_load_cnt) begin
          w_cap        = 1'b1;
          w_next_state = S_ARM;
        end
      end
      S_ARM: begin
        // tr_end may still be high from the previous transfer; wait for the
        // engine to drop it before looking for the new one.
        if (w_to_hit) begin
          w_to_fail    = 1'b1;
          w_next_state = S_CHECK;
        end else if (!bus.tr_end) begin
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        // tr_end wins over a timeout landing in the same cycle.
        if (bus.tr_end) begin
          w_next_state = S_CHECK;
        end else if (w_to_hit) begin
          w_to_fail    = 1'b1;
          w_next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_ok) begin
          if (w_last) begin
            w_next_state = S_DONE;
          end else begin
            w_idx_inc    = 1'b1;
`ifdef CAM_CFG_RETRY_EN
            w_retry_clr  = 1'b1;
`endif
            w_next_state = S_LOAD;
          end
        end else begin
`ifdef CAM_CFG_RETRY_EN
          if (r_retry_cnt < RTY_W'(MAX_RETRY)) begin
            w_retry_inc  = 1'b1;
            w_next_state = S_LOAD;
          end else begin
            w_next_state = S_ERR;
          end
`else
          w_next_state = S_ERR;
`endif
        end
      end
      S_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        if (cfg_restart) begin
          w_idx_clr    = 1'b1;
`ifdef CAM_CFG_RETRY_EN
          w_retry_clr  = 1'b1;
`endif
          w_next_state = S_LOAD;
        end
      end
      S_ERR: begin
        w_busy = 1'b0;
        w_err  = 1'b1;
        if (cfg_restart) begin
          w_idx_clr    = 1'b1;
`ifdef CAM_CFG_RETRY_EN
          w_retry_clr  = 1'b1;
`endif
          w_next_state = S_LOAD;
        end
      end
      default: begin
        w_next_state = S_PWR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i2c or negedge camera_rstn) begin
    if (!camera_rstn) begin
      r_dly_cnt   <= '0;
      r_load_cnt  <= 1'b0;
      r_to_cnt    <= '0;
      r_to_flag   <= 1'b0;
      r_lut_index <= '0;
      r_i2c_data  <= '0;
    end else begin
      if (r_state == S_PWR) r_dly_cnt <= r_dly_cnt + DLY_W'(1);
      else                  r_dly_cnt <= '0;

      if (r_state == S_LOAD) r_load_cnt <= ~r_load_cnt;
      else                   r_load_cnt <= 1'b0;

      // One timeout window spans ARM and BUSY together.
      if (r_state == S_ARM || r_state == S_BUSY) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                                       r_to_cnt <= '0;

      r_to_flag <= w_to_fail;

      if (w_idx_clr)      r_lut_index <= '0;
      else if (w_idx_inc) r_lut_index <= r_lut_index + IDX_W'(1);

      if (w_cap) r_i2c_data <= {DEV_ADDR, bus.lut_data};
    end
  end

`ifdef CAM_CFG_RETRY_EN
  always_ff @(posedge clock_i2c or negedge camera_rstn) begin
    if (!camera_rstn) begin
      r_retry_cnt <= '0;
    end else if (w_retry_clr) begin
      r_retry_cnt <= '0;
    end else if (w_retry_inc) begin
      r_retry_cnt <= r_retry_cnt + RTY_W'(1);
    end
  end
`endif

  assign bus.lut_index = r_lut_index;
  assign bus.i2c_data  = r_i2c_data;
  assign bus.start     = w_start;
  assign cfg_busy      = w_busy;
  assign cfg_done      = w_done;
  assign cfg_err       = w_err;

endmodule
